// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable integer clock divider.
package clk_div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    localparam int MIN_RATIO = 2;

    // High-phase length for a divide ratio N: floor(N/2) cycles.
    function automatic int high_len(input int n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clk_div_shadow.sv
// Active/shadow divide-ratio registers; loads are clamped and the last load
// before a period boundary is the one that takes effect there.
module clk_div_shadow
    import clk_div_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int DEF_RATIO = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idle,
    input  logic             boundary,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_ratio,
    output logic [CNT_W-1:0] ratio,
    output logic             pend_vld
);

    logic [CNT_W-1:0] pend_ratio;
    logic [CNT_W-1:0] load_val;

    function automatic logic [CNT_W-1:0] clamp_ratio(input logic [CNT_W-1:0] n);
        return (n < CNT_W'(MIN_RATIO)) ? CNT_W'(MIN_RATIO) : n;
    endfunction

    assign load_val = clamp_ratio(div_ratio);

    // A load in the boundary cycle itself bypasses the shadow and governs the
    // period that starts at that boundary.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ratio    <= CNT_W'(DEF_RATIO);
            pend_vld <= 1'b0;
        end else if (idle) begin
            if (div_load) ratio <= load_val;
        end else if (boundary) begin
            if (div_load)      ratio <= load_val;
            else if (pend_vld) ratio <= pend_ratio;
            pend_vld <= 1'b0;
        end else if (div_load) begin
            pend_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (div_load && !idle) pend_ratio <= load_val;
    end

endmodule

// File: rtl/clk_div.sv
// Glitch-free programmable integer clock divider: FSM, period counter and
// registered clk_out/tick; ratio changes and stops land on period boundaries.
module clk_div
    import clk_div_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int DEF_RATIO = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_ratio,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             active,
    output logic             ratio_pend
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] ratio;
    logic [CNT_W-1:0] high;
    logic             boundary;

    assign cnt_inc  = cnt + ONE;
    assign high     = CNT_W'(high_len(int'(ratio)));
    assign boundary = (state != IDLE) && (cnt == ratio - ONE);

    clk_div_shadow #(
        .CNT_W     (CNT_W),
        .DEF_RATIO (DEF_RATIO)
    ) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .idle      (state == IDLE),
        .boundary  (boundary),
        .div_load  (div_load),
        .div_ratio (div_ratio),
        .ratio     (ratio),
        .pend_vld  (ratio_pend)
    );

    // RUN and STOP count identically; en only matters at the period boundary
    // (restart vs. go idle) and to record which of the two we are in.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            active  <= 1'b0;
        end else begin
            tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state   <= RUN;
                        active  <= 1'b1;
                        cnt     <= '0;
                        clk_out <= 1'b1;
                        tick    <= 1'b1;
                    end
                end
                default: begin
                    if (boundary) begin
                        cnt <= '0;
                        if (en) begin
                            state   <= RUN;
                            clk_out <= 1'b1;
                            tick    <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            clk_out <= 1'b0;
                            active  <= 1'b0;
                        end
                    end else begin
                        cnt     <= cnt_inc;
                        clk_out <= (cnt_inc < high);
                        state   <= en ? RUN : STOP;
                    end
                end
            endcase
        end
    end

endmodule
